// File: rtl/pipeline_result_sink.sv
// Result sink for a fixed-latency, valid-less arithmetic pipeline: a tag delay line
// qualifies F, and qualified results land in a first-word-fall-through FIFO.
module pipeline_result_sink #(
  parameter int N       = 10,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [N-1:0]               f_in,
  output logic [N-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [CNT_W-1:0]           result_count
);
  localparam int AW = $clog2(DEPTH);

  // Stage 0 is the live strobe; stage LATENCY lines up with valid F.
  logic [LATENCY-1:0] tag;
  logic [LATENCY:0]   vld_pipe;
  logic               cap;

  assign vld_pipe = {tag, issue_valid};
  assign cap      = vld_pipe[LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) tag <= '0;
    else        tag <= vld_pipe[LATENCY-1:0];
  end

  logic [N-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         full, empty, pop, push, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = out_valid && out_ready;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push  = cap && (!full || pop);
  assign drop  = cap && full && !pop;

  assign out_valid  = !empty;
  assign out_data   = mem[rd_ptr[AW-1:0]];
  assign fill_level = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr[AW-1:0]] <= f_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      overflow     <= 1'b0;
      result_count <= '0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        result_count <= result_count + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end
endmodule
